// File: rtl/mmio_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : mmio_uart_tx
// Purpose  : Memory-mapped 8N1 serial transmitter with a byte FIFO, a status
//            register and a halt-done flag (kraj) for the processor data bus.
// Revision : 1.0 - initial release
// ============================================================================
module mmio_uart_tx #(
  parameter int               WIDTH        = 8,
  parameter int               DEPTH        = 4,
  parameter int               CLKS_PER_BIT = 4,
  parameter logic [WIDTH-1:0] TX_ADR       = WIDTH'(8'hF0),
  parameter logic [WIDTH-1:0] STAT_ADR     = WIDTH'(8'hF1),
  parameter logic [WIDTH-1:0] HALT_ADR     = WIDTH'(8'hF2)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             memread,
  input  logic             memwrite,
  input  logic [WIDTH-1:0] adr,
  input  logic [WIDTH-1:0] writedata,
  output logic [WIDTH-1:0] rdata,
  output logic             sel,
  output logic             txd,
  output logic             kraj
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [CW-1:0] C_DEPTH     = CW'(DEPTH);
  localparam logic [BW-1:0] C_BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_ovf;
  logic          r_halt;
  logic          r_kraj;
  logic          r_txd;
  logic [1:0]    r_state;
  logic [BW-1:0] r_baud;
  logic [2:0]    r_bit;
  logic [7:0]    r_shreg;

  logic w_wr_tx;
  logic w_wr_halt;
  logic w_stat_rd;
  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;
  logic w_ovf_set;
  logic w_busy;
  logic w_baud_end;

  assign w_wr_tx    = memwrite && (adr == TX_ADR);
  assign w_wr_halt  = memwrite && (adr == HALT_ADR);
  assign w_stat_rd  = memread && (adr == STAT_ADR);
  assign w_full     = (r_count == C_DEPTH);
  assign w_empty    = (r_count == '0);
  // A write arriving while full is dropped even if a pop frees a slot this cycle.
  assign w_push     = w_wr_tx && !w_full;
  assign w_ovf_set  = w_wr_tx && w_full;
  assign w_baud_end = (r_baud == C_BAUD_LAST);
  assign w_pop      = !w_empty && ((r_state == S_IDLE) ||
                                   ((r_state == S_STOP) && w_baud_end));
  assign w_busy     = !w_empty || (r_state != S_IDLE);

  assign sel   = (adr == TX_ADR) || (adr == STAT_ADR) || (adr == HALT_ADR);
  assign rdata = w_stat_rd ? {{(WIDTH-3){1'b0}}, r_ovf, w_full, w_busy} : '0;
  assign txd   = r_txd;
  assign kraj  = r_kraj;

  // FIFO storage; contents need no reset since pointers define validity.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= writedata[7:0];
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH (power of 2).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky overflow (set wins over read-clear), halt request and halt-done flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ovf  <= 1'b0;
      r_halt <= 1'b0;
      r_kraj <= 1'b0;
    end else begin
      if (w_ovf_set)      r_ovf <= 1'b1;
      else if (w_stat_rd) r_ovf <= 1'b0;
      if (w_wr_halt)      r_halt <= 1'b1;
      if (r_halt && !w_busy) r_kraj <= 1'b1;
    end
  end

  // Frame sequencer: start, 8 data bits LSB first, stop; chains frames without a gap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shreg <= '0;
    end else begin
      if (w_pop) r_shreg <= r_mem[r_rd_ptr];
      case (r_state)
        S_IDLE: begin
          r_baud <= '0;
          r_bit  <= '0;
          if (!w_empty) r_state <= S_START;
        end
        S_START: begin
          if (w_baud_end) begin
            r_baud  <= '0;
            r_bit   <= '0;
            r_state <= S_DATA;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        S_DATA: begin
          if (w_baud_end) begin
            r_baud  <= '0;
            r_shreg <= {1'b0, r_shreg[7:1]};
            if (r_bit == 3'd7) r_state <= S_STOP;
            else               r_bit   <= r_bit + 1'b1;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        default: begin
          if (w_baud_end) begin
            r_baud  <= '0;
            r_state <= w_empty ? S_IDLE : S_START;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
      endcase
    end
  end

  // Registered line driver: follows the sequencer one cycle later, glitch-free.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_txd <= 1'b1;
    end else begin
      case (r_state)
        S_START: r_txd <= 1'b0;
        S_DATA:  r_txd <= r_shreg[0];
        default: r_txd <= 1'b1;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mmio_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_mmio_uart_tx
// Purpose  : Directed self-checking bench for mmio_uart_tx.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mmio_uart_tx;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       memread = 1'b0;
  logic       memwrite = 1'b0;
  logic [7:0] adr = 8'h00;
  logic [7:0] writedata = 8'h00;
  logic [7:0] rdata;
  logic       sel;
  logic       txd;
  logic       kraj;

  int checks = 0;
  int failures = 0;

  mmio_uart_tx dut (
    .clk       (clk),
    .reset     (reset),
    .memread   (memread),
    .memwrite  (memwrite),
    .adr       (adr),
    .writedata (writedata),
    .rdata     (rdata),
    .sel       (sel),
    .txd       (txd),
    .kraj      (kraj)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    memread  = 1'b0;
    memwrite = 1'b0;
    adr      = 8'h00;
    reset    = 1'b1;
    tick();
    reset    = 1'b0;
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
    adr       = a;
    writedata = d;
    memwrite  = 1'b1;
    tick();
    memwrite  = 1'b0;
    adr       = 8'h00;
  endtask

  // Status read spanning one clock edge (the edge that clears overflow).
  task automatic stat_read(input string tag, input logic [7:0] exp);
    memread = 1'b1;
    adr     = 8'hF1;
    #1;
    chk(tag, rdata, exp);
    tick();
    memread = 1'b0;
    adr     = 8'h00;
  endtask

  // Expected line level at cycle i (0..39) of an 8N1 frame of byte d, 4 clk/bit.
  function automatic logic exp_bit(input logic [7:0] d, input int i);
    if (i < 4)       return 1'b0;
    else if (i < 36) return d[(i - 4) / 4];
    else             return 1'b1;
  endfunction

  logic [7:0] q3 [3];

  initial begin
    q3[0] = 8'h12; q3[1] = 8'h34; q3[2] = 8'h56;

    // Reset state
    tick();
    chk("rst_txd", txd, 1'b1);
    chk("rst_kraj", kraj, 1'b0);
    reset = 1'b0;
    stat_read("rst_stat", 8'h00);

    // 1: single byte A5, exact waveform and latency
    bus_write(8'hF0, 8'hA5);
    chk("t1_lat0", txd, 1'b1);
    tick();
    chk("t1_lat1", txd, 1'b1);
    tick();
    for (int i = 0; i < 40; i++) begin
      chk($sformatf("t1_bit%0d", i), txd, exp_bit(8'hA5, i));
      tick();
    end
    chk("t1_idle", txd, 1'b1);
    stat_read("t1_stat_idle", 8'h00);

    // 2: fill FIFO, overflow, read-clear of overflow
    do_reset();
    for (int i = 0; i < 5; i++) bus_write(8'hF0, 8'h10 + 8'(i));
    stat_read("t2_full_noovf", 8'h03);
    bus_write(8'hF0, 8'h77);
    stat_read("t2_ovf_set", 8'h07);
    stat_read("t2_ovf_clr", 8'h03);

    // 3: three back-to-back frames with busy held throughout
    do_reset();
    bus_write(8'hF0, q3[0]);
    bus_write(8'hF0, q3[1]);
    bus_write(8'hF0, q3[2]);
    memread = 1'b1;
    adr     = 8'hF1;
    #1;
    for (int i = 0; i < 121; i++) begin
      if (i < 120) chk($sformatf("t3_txd%0d", i), txd, exp_bit(q3[i / 40], i % 40));
      if (i < 119) chk($sformatf("t3_busy%0d", i), rdata[0], 1'b1);
      if (i == 120) chk("t3_busy_end", rdata[0], 1'b0);
      tick();
    end
    memread = 1'b0;
    adr     = 8'h00;

    // 4: halt after a queued byte, then halt with an empty FIFO
    do_reset();
    bus_write(8'hF0, 8'h41);
    bus_write(8'hF2, 8'h00);
    for (int i = 1; i <= 41; i++) begin
      chk($sformatf("t4_kraj0_%0d", i), kraj, 1'b0);
      tick();
    end
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t4_kraj1_%0d", i), kraj, 1'b1);
      tick();
    end
    do_reset();
    chk("t4b_rst_kraj", kraj, 1'b0);
    bus_write(8'hF2, 8'h00);
    chk("t4b_kraj_pre", kraj, 1'b0);
    tick();
    chk("t4b_kraj_post", kraj, 1'b1);

    // 5: reset during DATA, then a clean frame of 00
    do_reset();
    bus_write(8'hF0, 8'hF0);
    for (int i = 0; i < 6; i++) tick();
    chk("t5_data_bit0", txd, 1'b0);
    reset = 1'b1;
    #1;
    chk("t5_rst_txd", txd, 1'b1);
    chk("t5_rst_kraj", kraj, 1'b0);
    memread = 1'b1;
    adr     = 8'hF1;
    #1;
    chk("t5_rst_stat", rdata, 8'h00);
    memread = 1'b0;
    adr     = 8'h00;
    tick();
    reset = 1'b0;
    bus_write(8'hF0, 8'h00);
    chk("t5_lat0", txd, 1'b1);
    tick();
    chk("t5_lat1", txd, 1'b1);
    tick();
    for (int i = 0; i < 40; i++) begin
      chk($sformatf("t5_bit%0d", i), txd, exp_bit(8'h00, i));
      tick();
    end
    chk("t5_idle", txd, 1'b1);

    // 6: read decode and address select
    memread = 1'b1; adr = 8'h10; #1;
    chk("t6_rd_other", rdata, 8'h00);
    memread = 1'b0; adr = 8'hF1; #1;
    chk("t6_nord_stat", rdata, 8'h00);
    adr = 8'hF0; #1; chk("t6_sel_f0", sel, 1'b1);
    adr = 8'hF1; #1; chk("t6_sel_f1", sel, 1'b1);
    adr = 8'hF2; #1; chk("t6_sel_f2", sel, 1'b1);
    adr = 8'hEF; #1; chk("t6_sel_ef", sel, 1'b0);
    adr = 8'hF3; #1; chk("t6_sel_f3", sel, 1'b0);
    adr = 8'h00; #1; chk("t6_sel_00", sel, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
